dmem_port_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the single shared data-memory port behind the coherence bus. Serialises cpu0/cpu1 memory reads and writes, including uncached accesses, miss fills and write-backs, onto one variable-latency memory interface. Grants round-robin and supports a bounded lock for back-to-back transactions by one CPU. Sits between the CPU miss/uncached request logic and dmem, and drives the memory strobes that the snooping bus controller otherwise waits on via its ready input.

---
 rtl/dmem_port_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter/sequencer putting two CPU requesters onto one variable-latency dmem port.
// Optional memory-wait timeout is compiled in with `define ARB_TIMEOUT_EN.
module dmem_port_arbiter #(
  parameter int AW          = 13,
  parameter int DW          = 16,
  parameter int MAX_LOCK    = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_0,
  input  logic          req_1,
  input  logic          we_0,
  input  logic          we_1,
  input  logic          lock_0,
  input  logic          lock_1,
  input  logic [AW-1:0] addr_0,
  input  logic [AW-1:0] addr_1,
  input  logic [DW-1:0] wdata_0,
  input  logic [DW-1:0] wdata_1,
  output logic          gnt_0,
  output logic          gnt_1,
  output logic          done_0,
  output logic          done_1,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rdy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  localparam int LCW = $clog2(MAX_LOCK + 1);

  if (MAX_LOCK < 1 || TIMEOUT_CYC < 2) begin : g_param_chk
    $error("dmem_port_arbiter: MAX_LOCK must be >= 1 and TIMEOUT_CYC >= 2");
  end

  state_t         r_state, w_state_nxt;
  logic [1:0]     r_gnt, w_gnt_nxt;
  logic           r_we, w_we_nxt;
  logic           r_last, w_last_nxt;
  logic           r_lock_vld, w_lock_vld_nxt;
  logic           r_lock_own, w_lock_own_nxt;
  logic [LCW-1:0] r_lock_cnt, w_lock_cnt_nxt;
  logic [AW-1:0]  r_addr, w_addr_nxt;
  logic [DW-1:0]  r_wdata, w_wdata_nxt;
  logic [DW-1:0]  r_rdata, w_rdata_nxt;
  logic           r_err, w_err_nxt;

  logic [1:0]     w_req;
  logic [1:0]     w_lock_in;
  logic           w_cur;
  logic           w_sel_vld;
  logic           w_sel;
  logic           w_timeout;

  assign w_req     = {req_1, req_0};
  assign w_lock_in = {lock_1, lock_0};
  assign w_cur     = r_gnt[1];

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC);
  logic [TW-1:0] r_wait;

  // Counter is only meaningful in ACCESS; it restarts on every ACCESS entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait <= '0;
    end else if (r_state != S_ACCESS) begin
      r_wait <= '0;
    end else begin
      r_wait <= r_wait + TW'(1);
    end
  end

  assign w_timeout = (r_state == S_ACCESS) && !mem_rdy && (r_wait == TW'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_we_nxt       = r_we;
    w_last_nxt     = r_last;
    w_lock_vld_nxt = r_lock_vld;
    w_lock_own_nxt = r_lock_own;
    w_lock_cnt_nxt = r_lock_cnt;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_rdata_nxt    = r_rdata;
    w_err_nxt      = 1'b0;
    w_sel_vld      = 1'b0;
    w_sel          = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_gnt_nxt = 2'b00;
        if (r_lock_vld && w_req[r_lock_own]) begin
          w_sel_vld = 1'b1;
          w_sel     = r_lock_own;
        end else begin
          // An owner that stopped requesting forfeits the lock immediately.
          if (r_lock_vld) begin
            w_lock_vld_nxt = 1'b0;
            w_lock_own_nxt = 1'b0;
            w_lock_cnt_nxt = '0;
          end
          if (req_0 && req_1) begin
            w_sel_vld = 1'b1;
            w_sel     = ~r_last;
          end else if (req_0) begin
            w_sel_vld = 1'b1;
            w_sel     = 1'b0;
          end else if (req_1) begin
            w_sel_vld = 1'b1;
            w_sel     = 1'b1;
          end
        end
        if (w_sel_vld) begin
          w_gnt_nxt   = w_sel ? 2'b10 : 2'b01;
          w_addr_nxt  = w_sel ? addr_1  : addr_0;
          w_wdata_nxt = w_sel ? wdata_1 : wdata_0;
          w_we_nxt    = w_sel ? we_1    : we_0;
          w_state_nxt = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (mem_rdy) begin
          if (!r_we) begin
            w_rdata_nxt = mem_rdata;
          end
          w_state_nxt = S_DONE;
        end else if (w_timeout) begin
          w_rdata_nxt = '0;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        w_last_nxt  = w_cur;
        w_gnt_nxt   = 2'b00;
        w_state_nxt = S_IDLE;
        // A timed-out owner never keeps the port.
        if (!r_err && w_lock_in[w_cur] && (r_lock_cnt < LCW'(MAX_LOCK - 1))) begin
          w_lock_vld_nxt = 1'b1;
          w_lock_own_nxt = w_cur;
          w_lock_cnt_nxt = r_lock_cnt + LCW'(1);
        end else begin
          w_lock_vld_nxt = 1'b0;
          w_lock_own_nxt = 1'b0;
          w_lock_cnt_nxt = '0;
        end
      end

      default: begin
        w_gnt_nxt   = 2'b00;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gnt      <= 2'b00;
      r_we       <= 1'b0;
      r_last     <= 1'b1;
      r_lock_vld <= 1'b0;
      r_lock_own <= 1'b0;
      r_lock_cnt <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_we       <= w_we_nxt;
      r_last     <= w_last_nxt;
      r_lock_vld <= w_lock_vld_nxt;
      r_lock_own <= w_lock_own_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_rdata    <= w_rdata_nxt;
      r_err      <= w_err_nxt;
    end
  end

  // Strobes and done are decoded from state so that reset removes them without a clock.
  assign gnt_0     = r_gnt[0];
  assign gnt_1     = r_gnt[1];
  assign done_0    = (r_state == S_DONE) && r_gnt[0];
  assign done_1    = (r_state == S_DONE) && r_gnt[1];
  assign mem_re    = (r_state == S_ACCESS) && !r_we;
  assign mem_we    = (r_state == S_ACCESS) && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign rdata     = r_rdata;
  assign err       = r_err;

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) !(gnt_0 && gnt_1));
  a_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n) !(mem_re && mem_we));

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: vector table plus hand sequences, checked through a scoreboard.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;
  localparam int AW = 13;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_0 = 1'b0, req_1 = 1'b0, we_0 = 1'b0, we_1 = 1'b0;
  logic          lock_0 = 1'b0, lock_1 = 1'b0;
  logic [AW-1:0] addr_0 = '0, addr_1 = '0;
  logic [DW-1:0] wdata_0 = '0, wdata_1 = '0;
  logic          gnt_0, gnt_1, done_0, done_1, err, mem_re, mem_we;
  logic [DW-1:0] rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_rdy = 1'b0;

  dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(4), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
    .lock_0(lock_0), .lock_1(lock_1), .addr_0(addr_0), .addr_1(addr_1),
    .wdata_0(wdata_0), .wdata_1(wdata_1),
    .gnt_0(gnt_0), .gnt_1(gnt_1), .done_0(done_0), .done_1(done_1),
    .rdata(rdata), .err(err), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            id;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            strobes;
    logic          err;
  } exp_t;

  typedef struct {
    logic          r0, r1, w0, w1, k0, k1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    int            lat;
    int            id;
  } vec_t;

  int            total = 0;
  int            bad = 0;
  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] exp_hold = '0;
  int            cur_lat = 0;
  int            scnt = 0;
  int            stb_cnt = 0;
  vec_t          tv[12];

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    if (a == 13'h0A5) return 16'hBEEF;
    return {3'b000, a} ^ 16'h5A5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_exp(input int id, input logic [AW-1:0] a, input logic we,
                          input logic [DW-1:0] wd, input int strobes, input logic to);
    exp_t e;
    if (to) exp_hold = '0;
    else if (!we) exp_hold = mdata(a);
    e.id = id; e.addr = a; e.we = we; e.wdata = wd;
    e.rdata = exp_hold; e.strobes = strobes; e.err = to;
    sb.push_back(e);
  endtask

  // Counts rising edges until n done pulses have been seen; returns in the last DONE cycle.
  task automatic wait_dones(input int n, input int budget, output int cyc);
    int seen;
    seen = 0;
    cyc = 0;
    while (seen < n && cyc < budget) begin
      @(posedge clk); #1;
      cyc++;
      if (done_0 || done_1) seen++;
    end
    check("done_seen", seen, n);
  endtask

  task automatic clear_reqs();
    req_0 = 1'b0; req_1 = 1'b0; we_0 = 1'b0; we_1 = 1'b0; lock_0 = 1'b0; lock_1 = 1'b0;
  endtask

  // Memory model: mem_rdy rises cur_lat cycles after a strobe first appears.
  always @(negedge clk) begin
    if (mem_re || mem_we) begin
      mem_rdy   = (scnt >= cur_lat);
      mem_rdata = mdata(mem_addr);
      scnt++;
    end else begin
      mem_rdy   = 1'b0;
      mem_rdata = 16'hDEAD;
      scnt      = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stb_cnt = 0;
    end else begin
      check("gnt_onehot", {31'd0, gnt_0 & gnt_1}, 0);
      check("strobe_excl", {31'd0, mem_re & mem_we}, 0);
      if (mem_re || mem_we) begin
        stb_cnt++;
        if (stb_cnt == 1) begin
          if (sb.size() == 0) begin
            check("stray_strobe", sb.size(), 1);
          end else begin
            check("mem_addr", mem_addr, sb[0].addr);
            check("mem_dir", mem_we, sb[0].we);
            check("gnt_owner", {gnt_1, gnt_0}, sb[0].id ? 2 : 1);
            if (sb[0].we) check("mem_wdata", mem_wdata, sb[0].wdata);
          end
        end
      end
      if (done_0 || done_1) begin
        if (sb.size() == 0) begin
          check("stray_done", sb.size(), 1);
        end else begin
          mon_e = sb.pop_front();
          check("done_id", {done_1, done_0}, mon_e.id ? 2 : 1);
          check("done_gnt", {gnt_1, gnt_0}, mon_e.id ? 2 : 1);
          check("rdata", rdata, mon_e.rdata);
          check("err", err, mon_e.err);
          check("strobe_cycles", stb_cnt, mon_e.strobes);
        end
        stb_cnt = 0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    //            r0    r1    w0    w1    k0    k1    a0        a1        d0        d1      lat id
    tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h00A5, 13'h0B00, 16'h1111, 16'h2222, 2, 0};
    tv[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 13'h0C00, 13'h01FF, 16'h3333, 16'h1234, 0, 1};
    tv[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0010, 13'h0020, 16'h0000, 16'h0000, 1, 0};
    tv[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0011, 13'h0021, 16'h0000, 16'h0000, 0, 1};
    tv[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 13'h0D00, 13'h00FF, 16'h4444, 16'hCAFE, 3, 1};
    tv[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 13'h1000, 13'h1ABC, 16'hFFFF, 16'h5555, 1, 0};
    tv[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h1FFF, 13'h0E00, 16'h0000, 16'h0000, 1, 0};
    tv[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0033, 13'h0044, 16'h0000, 16'h0000, 0, 1};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 13'h0055, 13'h0F00, 16'h0000, 16'h0000, 0, 0};
    tv[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0A00, 13'h0066, 16'h0000, 16'h0000, 1, 1};
    tv[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0077, 13'h0088, 16'h0000, 16'h0000, 0, 0};
    tv[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 13'h0900, 13'h0099, 16'h6666, 16'h0F0F, 2, 1};

    // Outputs while reset is held.
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", {gnt_1, gnt_0}, 0);
    check("rst_done", {done_1, done_0}, 0);
    check("rst_strobes", {mem_re, mem_we}, 0);
    check("rst_err", err, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rdata", rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_gnt", {gnt_1, gnt_0}, 0);

    // Latency counts rising edges from the drive: the sampling cycle is the first of
    // IDLE/ACCESS/DONE, so done appears 2 + lat edges later.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req_0 = tv[i].r0; req_1 = tv[i].r1; we_0 = tv[i].w0; we_1 = tv[i].w1;
      lock_0 = tv[i].k0; lock_1 = tv[i].k1;
      addr_0 = tv[i].a0; addr_1 = tv[i].a1; wdata_0 = tv[i].d0; wdata_1 = tv[i].d1;
      cur_lat = tv[i].lat;
      if (tv[i].id == 1) push_exp(1, tv[i].a1, tv[i].w1, tv[i].d1, tv[i].lat + 1, 1'b0);
      else               push_exp(0, tv[i].a0, tv[i].w0, tv[i].d0, tv[i].lat + 1, 1'b0);
      wait_dones(1, 40, cyc);
      check("latency", cyc, 2 + tv[i].lat);
      clear_reqs();
      @(posedge clk);
    end

    // Lock: cpu0 holds the port for MAX_LOCK grants while cpu1 waits, then cpu1 is served.
    @(negedge clk);
    req_0 = 1'b1; req_1 = 1'b1; lock_0 = 1'b1;
    addr_0 = 13'h0100; addr_1 = 13'h0200;
    cur_lat = 0;
    for (int k = 0; k < 4; k++) push_exp(0, 13'h0100, 1'b0, 16'h0, 1, 1'b0);
    push_exp(1, 13'h0200, 1'b0, 16'h0, 1, 1'b0);
    wait_dones(5, 80, cyc);
    clear_reqs();
    @(posedge clk);

    // Asynchronous reset in the middle of an access.
    @(negedge clk);
    req_0 = 1'b1; req_1 = 1'b1; addr_0 = 13'h0300; addr_1 = 13'h0400;
    cur_lat = 1000;
    push_exp(0, 13'h0300, 1'b0, 16'h0, 1, 1'b0);
    cyc = 0;
    while (!mem_re && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reached_access", mem_re, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gnt", {gnt_1, gnt_0}, 0);
    check("arst_strobes", {mem_re, mem_we}, 0);
    check("arst_mem_addr", mem_addr, 0);
    check("arst_rdata", rdata, 0);
    sb.delete();
    exp_hold = '0;
    @(negedge clk);
    cur_lat = 0;
    push_exp(0, 13'h0300, 1'b0, 16'h0, 1, 1'b0);
    push_exp(1, 13'h0400, 1'b0, 16'h0, 1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_dones(2, 40, cyc);
    clear_reqs();
    @(posedge clk);

`ifdef ARB_TIMEOUT_EN
    // Memory never answers: 8 ACCESS cycles, then an error completion with zero data.
    @(negedge clk);
    req_0 = 1'b1; addr_0 = 13'h0123;
    cur_lat = 1000;
    push_exp(0, 13'h0123, 1'b0, 16'h0, 8, 1'b1);
    wait_dones(1, 40, cyc);
    check("timeout_latency", cyc, 9);
    clear_reqs();
    @(posedge clk); #1;
    check("timeout_idle_gnt", {gnt_1, gnt_0}, 0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
